// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - mode constants and start patterns for the LED sequencer
package led_pkg;

    localparam logic [1:0] MODE_ROL   = 2'd0;
    localparam logic [1:0] MODE_ROR   = 2'd1;
    localparam logic [1:0] MODE_PING  = 2'd2;
    localparam logic [1:0] MODE_BLINK = 2'd3;

    localparam int LED_MAX = 16;

    // Returns the pattern a mode starts from; bits at or above led_num are zero.
    function automatic logic [LED_MAX-1:0] start_pattern(input logic [1:0] mode, input int led_num);
        logic [LED_MAX-1:0] p;
        p = '0;
        for (int i = 0; i < LED_MAX; i++) begin
            case (mode)
                MODE_ROR:   p[i] = (i == led_num - 1);
                MODE_BLINK: p[i] = (i < led_num);
                default:    p[i] = (i == 0);
            endcase
        end
        return p;
    endfunction

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - enable-gated prescaler producing a step tick
module step_timer #(
    parameter int unsigned STEP_CYCLES = 25_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Count holds while disabled so a paused step resumes where it stopped.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED bank pattern sequencer with selectable modes
module led_sequencer
    import led_pkg::*;
#(
    parameter int          LED_NUM     = 4,
    parameter int unsigned STEP_CYCLES = 25_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    output logic [LED_NUM-1:0] led,
    output logic               step_pulse
);

    logic               tick;
    logic [1:0]         mode_q;
    logic               dir;
    logic [LED_NUM-1:0] led_d;
    logic [LED_NUM-1:0] led_start;
    logic [1:0]         mode_d;
    logic               dir_d;

    step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_timer (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .en       (en),
        .tick     (tick)
    );

    assign led_start = LED_NUM'(start_pattern(mode, LED_NUM));

    always_comb begin
        led_d  = led;
        mode_d = mode_q;
        dir_d  = dir;
        if (tick) begin
            if (mode != mode_q) begin
                led_d  = led_start;
                mode_d = mode;
                dir_d  = 1'b0;
            end else begin
                case (mode_q)
                    MODE_ROL: led_d = {led[LED_NUM-2:0], led[LED_NUM-1]};
                    MODE_ROR: led_d = {led[0], led[LED_NUM-1:1]};
                    MODE_PING: begin
                        led_d = dir ? (led >> 1) : (led << 1);
                        // Turn around on arrival so an end position is shown only once.
                        if (led_d[LED_NUM-1]) begin
                            dir_d = 1'b1;
                        end else if (led_d[0]) begin
                            dir_d = 1'b0;
                        end
                    end
                    default: led_d = ~led;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            led        <= LED_NUM'(1);
            mode_q     <= MODE_ROL;
            dir        <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            led        <= led_d;
            mode_q     <= mode_d;
            dir        <= dir_d;
            step_pulse <= tick;
        end
    end

endmodule
